alu_control_md: RTL and testbench
=================================

# alu_control_md

Parametrised successor to the EX-stage ALU control decoder. Keeps the combinational `control` decode from {`op`, `funct`} and adds an iterative multiply/divide sequencer with HI/LO registers and a pipeline stall handshake. The block sits between the ID/EX register and the ALU/forwarding logic in EX. It lets the MIPS core execute MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO without a separate unit.

## Interface
- `WIDTH`, 32: data width of operands, HI and LO.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous and active-low (fixed).
- `op` in 2: ALUOp from main control.
- `funct` in 6: instruction funct field.
- `valid` in 1: EX holds a real instruction this cycle.
- `rs_val` in WIDTH: operand A (multiplicand/dividend, MTHI/MTLO source).
- `rt_val` in WIDTH: operand B (multiplier/divisor).
- `control` out 4: ALU select, combinational.
- `md_stall` out 1: combinational; freeze IF/ID/EX this cycle.
- `md_busy` out 1: registered; sequencer running.
- `md_done` out 1: registered; one-cycle pulse when HI/LO update from MUL/DIV.
- `md_rsel` out 1: combinational; EX instruction is MFHI/MFLO, so the writeback mux takes `md_rdata`.
- `md_rdata` out WIDTH: HI for MFHI, LO for MFLO, else 0.
- `hi`, `lo` out WIDTH: architectural HI/LO.

## Operation
- **`control` decode**, unchanged:
  - op 00 → 0010; op 01 → 0110.
  - op 10 with funct 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 100110 → 0011, 101010 → 0111.
  - New: op 10 with funct 100111 (NOR) → 1100.
  - Everything else → 0000.
- **MD funct codes** (op 10 only): MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- **Accept**: valid && MUL/DIV funct && state IDLE.
  - Latch operands.
  - Signed ops take magnitudes and record the result signs.
- **FSM**: IDLE → (accept MUL) MUL / (accept DIV) DIV → FIX → IDLE.
  - MUL: shift-add, one bit per cycle, exactly WIDTH cycles; 2·WIDTH product.
  - DIV: restoring, one quotient bit per cycle, exactly WIDTH cycles.
  - FIX: apply sign correction, write HI/LO, pulse `md_done`.
- **Results**:
  - MULT/MULTU: {HI, LO} = product.
  - DIV/DIVU: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero (any sign): LO = all ones, HI = `rs_val`. No trap.
  - Signed MIN / −1: LO = MIN, HI = 0.
- **MTHI/MTLO**: when valid and IDLE, write HI/LO at the edge; no busy. While busy, they stall.
- **MFHI/MFLO**: when not busy, `md_rdata` = current HI/LO, combinationally.
- **`md_stall`** = valid && (state ≠ IDLE) && funct ∈ any MD code && op == 10.
  - Non-MD instructions are never stalled.
  - Any MD instruction issued while busy is held, not dropped or queued.
- Non-MD instructions never alter sequencer state or HI/LO.

## Timing
- Reset (rst_n low at an edge), including mid-operation:
  - State → IDLE; HI = LO = 0; `md_busy` = `md_done` = 0.
  - The in-flight result is discarded.
- MUL/DIV accepted at edge E:
  - `md_busy` is high after E through edge E+WIDTH+1.
  - After edge E+WIDTH+1: HI/LO hold the new values, `md_busy` = 0, `md_done` = 1 for exactly that cycle.
  - Total latency is WIDTH+2 edges; 34 for WIDTH = 32.
- Back-to-back: a MD instruction stalled on the final busy cycle is accepted at edge E+WIDTH+2.
  - The next instruction sees the updated HI/LO in the same cycle that `md_done` is high.
- Same-cycle MTHI/MTLO and accept are impossible: one instruction per EX slot.
- `control`, `md_stall`, `md_rsel` and `md_rdata` have zero latency.

## Configuration
- Macro `ALU_CONTROL_MD_DIV_EN`.
- **Defined**: DIV/DIVU are supported as above.
- **Undefined**:
  - DIV state and divider datapath are removed.
  - DIV/DIVU are treated as no-ops: no accept, no stall, HI/LO unchanged, `control` 0000.
  - MUL, MT, MF and the ALU decode are unchanged.

## Test plan
- **Decode sweep**: every op/funct listed → exact `control` code (NOR → 1100); unlisted funct with op 10 → 0000.
- **MULT signed, WIDTH 32**: rs = 0xFFFFFFFD (−3), rt = 7 → after 34 edges HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; `md_done` high one cycle; `md_busy` high for exactly 33 cycles.
- **DIV signed**: −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Divide by zero with rs = 5 → LO = 0xFFFFFFFF, HI = 5. 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- **Interlock**: MFLO issued 2 cycles after MULTU 0xFFFFFFFF × 2 → `md_stall` high until `md_done`; then `md_rdata` = 0xFFFFFFFE, HI = 1. An ADD issued while busy is never stalled.
- **Reset mid-DIV** at cycle 10 → next cycle HI = LO = 0, `md_busy` = 0, and no `md_done` ever fires for the aborted operation.
- **Macro off**: DIVU issued → no stall, HI/LO unchanged. MTHI 0x1234 then MFHI → `md_rdata` = 0x1234.

Source files
------------

// File: rtl/alu_control_md_if.sv
// EX-stage bundle between the ID/EX register and the ALU control / multiply-divide block.
interface alu_control_md_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       op;
    logic [5:0]       funct;
    logic             valid;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [3:0]       control;
    logic             md_stall;
    logic             md_busy;
    logic             md_done;
    logic             md_rsel;
    logic [WIDTH-1:0] md_rdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op, funct, valid, rs_val, rt_val,
        input  control, md_stall, md_busy, md_done, md_rsel, md_rdata, hi, lo
    );

    modport slave (
        input  op, funct, valid, rs_val, rt_val,
        output control, md_stall, md_busy, md_done, md_rsel, md_rdata, hi, lo
    );
endinterface

// File: rtl/alu_control_md.sv
// ALU control decode plus iterative MUL/DIV sequencer with HI/LO and stall interlock.
// Define ALU_CONTROL_MD_DIV_EN to include DIV/DIVU (restoring divider).
module alu_control_md #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_control_md_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef ALU_CONTROL_MD_DIV_EN
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIX
`ifdef ALU_CONTROL_MD_DIV_EN
        , S_DIV
`endif
    } state_t;

    state_t               state_reg, state_next;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     opb_reg;
    logic [CW-1:0]        cnt_reg;
    logic [WIDTH-1:0]     hi_reg, lo_reg;
    logic                 busy_reg, done_reg, negp_reg;
    logic [3:0]           control;

    logic is_r, is_mul, is_div, is_mf, is_mt, is_md, idle, cnt_last;
    logic accept_mul, accept_div, sign_a, sign_b;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, mul_res;

    assign is_r   = (bus.op == 2'b10);
    assign is_mul = is_r && (bus.funct == F_MULT || bus.funct == F_MULTU);
`ifdef ALU_CONTROL_MD_DIV_EN
    assign is_div = is_r && (bus.funct == F_DIV || bus.funct == F_DIVU);
`else
    assign is_div = 1'b0;
`endif
    assign is_mf  = is_r && (bus.funct == F_MFHI || bus.funct == F_MFLO);
    assign is_mt  = is_r && (bus.funct == F_MTHI || bus.funct == F_MTLO);
    assign is_md  = is_mul || is_div || is_mf || is_mt;
    assign idle   = (state_reg == S_IDLE);

    assign accept_mul = bus.valid && is_mul && idle;
    assign accept_div = bus.valid && is_div && idle;
    assign cnt_last   = (cnt_reg == CW'(WIDTH - 1));

    // Odd funct bit marks the unsigned variants.
    assign sign_a = !bus.funct[0] && bus.rs_val[WIDTH-1];
    assign sign_b = !bus.funct[0] && bus.rt_val[WIDTH-1];
    assign a_mag  = sign_a ? -bus.rs_val : bus.rs_val;
    assign b_mag  = sign_b ? -bus.rt_val : bus.rt_val;

    // Shift-add: low half holds the unconsumed multiplier bits.
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
    assign mul_res  = negp_reg ? -acc_reg : acc_reg;

`ifdef ALU_CONTROL_MD_DIV_EN
    logic               negr_reg, divz_reg, is_div_reg, div_fit;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_q, div_r;

    // Restoring step: high half is the partial remainder, low half the dividend/quotient.
    assign div_trial = {1'b0, acc_reg[2*WIDTH-1:WIDTH-1]} - {2'b00, opb_reg};
    assign div_fit   = (div_trial[WIDTH+1:WIDTH] == 2'b00);
    assign div_next  = div_fit ? {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1}
                               : {acc_reg[2*WIDTH-2:0], 1'b0};
    assign div_q     = acc_reg[WIDTH-1:0];
    assign div_r     = acc_reg[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        control = 4'b0000;
        case (bus.op)
            2'b00: control = 4'b0010;
            2'b01: control = 4'b0110;
            2'b10: begin
                case (bus.funct)
                    6'b100000: control = 4'b0010;
                    6'b100010: control = 4'b0110;
                    6'b100100: control = 4'b0000;
                    6'b100101: control = 4'b0001;
                    6'b100110: control = 4'b0011;
                    6'b101010: control = 4'b0111;
                    6'b100111: control = 4'b1100;
                    default:   control = 4'b0000;
                endcase
            end
            default: control = 4'b0000;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept_mul)
                    state_next = S_MUL;
`ifdef ALU_CONTROL_MD_DIV_EN
                else if (accept_div)
                    state_next = S_DIV;
`endif
            end
            S_MUL: if (cnt_last) state_next = S_FIX;
`ifdef ALU_CONTROL_MD_DIV_EN
            S_DIV: if (cnt_last) state_next = S_FIX;
`endif
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            opb_reg  <= '0;
            cnt_reg  <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            negp_reg <= 1'b0;
`ifdef ALU_CONTROL_MD_DIV_EN
            negr_reg   <= 1'b0;
            divz_reg   <= 1'b0;
            is_div_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept_mul || accept_div) begin
                        acc_reg  <= {{WIDTH{1'b0}}, a_mag};
                        opb_reg  <= b_mag;
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
                        negp_reg <= sign_a ^ sign_b;
`ifdef ALU_CONTROL_MD_DIV_EN
                        negr_reg   <= sign_a;
                        divz_reg   <= (bus.rt_val == '0);
                        is_div_reg <= accept_div;
`endif
                    end else if (bus.valid && is_mt) begin
                        if (bus.funct == F_MTHI)
                            hi_reg <= bus.rs_val;
                        else
                            lo_reg <= bus.rs_val;
                    end
                end
                S_MUL: begin
                    acc_reg <= mul_next;
                    cnt_reg <= cnt_reg + CW'(1);
                end
`ifdef ALU_CONTROL_MD_DIV_EN
                S_DIV: begin
                    acc_reg <= div_next;
                    cnt_reg <= cnt_reg + CW'(1);
                end
`endif
                S_FIX: begin
`ifdef ALU_CONTROL_MD_DIV_EN
                    // Divide by zero leaves an all-ones quotient and the untouched dividend in HI.
                    if (is_div_reg) begin
                        lo_reg <= divz_reg ? '1 : (negp_reg ? -div_q : div_q);
                        hi_reg <= negr_reg ? -div_r : div_r;
                    end else
`endif
                    begin
                        {hi_reg, lo_reg} <= mul_res;
                    end
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.control  = control;
    assign bus.md_stall = bus.valid && !idle && is_md;
    assign bus.md_busy  = busy_reg;
    assign bus.md_done  = done_reg;
    assign bus.md_rsel  = bus.valid && is_mf;
    assign bus.md_rdata = bus.md_rsel ? ((bus.funct == F_MFHI) ? hi_reg : lo_reg) : '0;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
endmodule

// File: tb/tb_alu_control_md.sv
// Directed bench for alu_control_md: decode table, MUL/DIV results via scoreboard, interlock, reset.
module tb_alu_control_md;
    localparam int W = 32;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_control_md_if #(.WIDTH(W)) bus ();
    alu_control_md #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every md_done must match the oldest outstanding MUL/DIV.
    always @(negedge clk) begin
        if (bus.md_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("md_done hi=%h lo=%h expected=%h", bus.hi, bus.lo, mon_exp);
                check("hilo_result", {bus.hi, bus.lo}, mon_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic v,
                         input logic [31:0] a, input logic [31:0] b);
        bus.op = op;
        bus.funct = f;
        bus.valid = v;
        bus.rs_val = a;
        bus.rt_val = b;
        #1;
    endtask

    task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int edges;
        int busy_n;
        exp_q.push_back({ehi, elo});
        issue(2'b10, f, 1'b1, a, b);
        check({name, "_stall_when_idle"}, 64'(bus.md_stall), 64'd0);
        step();
        issue(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);
        edges = 1;
        busy_n = 0;
        for (int i = 0; i < 60 && bus.md_done !== 1'b1; i++) begin
            if (bus.md_busy === 1'b1) busy_n++;
            step();
            edges++;
        end
        $display("%s rs=%h rt=%h edges=%0d busy_cycles=%0d", name, a, b, edges, busy_n);
        check({name, "_latency"}, 64'(edges), 64'd34);
        check({name, "_busy_cycles"}, 64'(busy_n), 64'd33);
        check({name, "_busy_low_at_done"}, 64'(bus.md_busy), 64'd0);
        step();
        check({name, "_done_one_cycle"}, 64'(bus.md_done), 64'd0);
    endtask

    logic [11:0] dec_tab [14] = '{
        {2'b00, 6'b100000, 4'b0010}, {2'b00, 6'b101010, 4'b0010},
        {2'b01, 6'b000000, 4'b0110}, {2'b01, 6'b100100, 4'b0110},
        {2'b10, 6'b100000, 4'b0010}, {2'b10, 6'b100010, 4'b0110},
        {2'b10, 6'b100100, 4'b0000}, {2'b10, 6'b100101, 4'b0001},
        {2'b10, 6'b100110, 4'b0011}, {2'b10, 6'b101010, 4'b0111},
        {2'b10, 6'b100111, 4'b1100}, {2'b10, 6'b000000, 4'b0000},
        {2'b10, 6'b011000, 4'b0000}, {2'b11, 6'b100000, 4'b0000}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stall_bad;
        logic [11:0] e;
        issue(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b0;
        repeat (3) step();
        check("reset_busy", 64'(bus.md_busy), 64'd0);
        check("reset_done", 64'(bus.md_done), 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        step();

        foreach (dec_tab[i]) begin
            e = dec_tab[i];
            issue(e[11:10], e[9:4], 1'b0, 32'd0, 32'd0);
            $display("decode op=%b funct=%b control=%b", e[11:10], e[9:4], bus.control);
            check($sformatf("decode_%0d", i), 64'(bus.control), 64'(e[3:0]));
        end

        run_md("mult_neg3x7",   F_MULT,  32'hFFFFFFFD, 32'd7,       32'hFFFFFFFF, 32'hFFFFFFEB);
        run_md("multu_big",     F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_md("mult_m1xm1",    F_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        run_md("multu_2p16",    F_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
`ifdef ALU_CONTROL_MD_DIV_EN
        run_md("div_m7_2",      F_DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("div_by_zero",   F_DIV,   32'd5,       32'd0,       32'h00000005, 32'hFFFFFFFF);
        run_md("div_min_m1",    F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_md("divu_100_7",    F_DIVU,  32'd100,     32'd7,       32'h00000002, 32'h0000000E);
`endif

        // Interlock: ADD during busy is free, MFLO waits until the result lands.
        exp_q.push_back({32'h00000001, 32'hFFFFFFFE});
        issue(2'b10, F_MULTU, 1'b1, 32'hFFFFFFFF, 32'd2);
        step();
        issue(2'b10, 6'b100000, 1'b1, 32'd3, 32'd4);
        check("add_busy_stall", 64'(bus.md_stall), 64'd0);
        check("add_busy_control", 64'(bus.control), 64'd2);
        check("add_rdata_zero", 64'(bus.md_rdata), 64'd0);
        step();
        issue(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);
        step();
        issue(2'b10, F_MFLO, 1'b1, 32'd0, 32'd0);
        n = 0;
        stall_bad = 0;
        while (n < 60 && bus.md_done !== 1'b1) begin
            if (bus.md_stall !== 1'b1) stall_bad++;
            step();
            n++;
        end
        $display("interlock mflo stalled_cycles=%0d rdata=%h hi=%h", n, bus.md_rdata, bus.hi);
        check("mflo_stall_held", 64'(stall_bad), 64'd0);
        check("mflo_stall_cycles", 64'(n), 64'd31);
        check("mflo_stall_released", 64'(bus.md_stall), 64'd0);
        check("mflo_rsel", 64'(bus.md_rsel), 64'd1);
        check("mflo_rdata", 64'(bus.md_rdata), 64'hFFFFFFFE);
        check("mflo_hi", 64'(bus.hi), 64'd1);
        step();
        issue(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);

        // Reset at cycle 10 of an operation: result discarded, no done afterwards.
`ifdef ALU_CONTROL_MD_DIV_EN
        issue(2'b10, F_DIV, 1'b1, 32'd1000, 32'd3);
`else
        issue(2'b10, F_MULT, 1'b1, 32'd1000, 32'd3);
`endif
        step();
        issue(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);
        repeat (9) step();
        check("busy_before_abort", 64'(bus.md_busy), 64'd1);
        rst_n = 1'b0;
        step();
        $display("abort reset hi=%h lo=%h busy=%b done=%b", bus.hi, bus.lo, bus.md_busy, bus.md_done);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_busy", 64'(bus.md_busy), 64'd0);
        check("abort_done", 64'(bus.md_done), 64'd0);
        rst_n = 1'b1;
        repeat (40) step();

        // MTHI/MTLO then MFHI/MFLO.
        issue(2'b10, F_MTHI, 1'b1, 32'h00001234, 32'd0);
        step();
        issue(2'b10, F_MTLO, 1'b1, 32'h00005678, 32'd0);
        check("mt_no_busy", 64'(bus.md_busy), 64'd0);
        step();
`ifndef ALU_CONTROL_MD_DIV_EN
        issue(2'b10, F_DIVU, 1'b1, 32'd100, 32'd7);
        check("divu_off_stall", 64'(bus.md_stall), 64'd0);
        check("divu_off_control", 64'(bus.control), 64'd0);
        step();
        check("divu_off_busy", 64'(bus.md_busy), 64'd0);
        check("divu_off_hilo", {bus.hi, bus.lo}, 64'h0000123400005678);
`endif
        issue(2'b10, F_MFHI, 1'b1, 32'd0, 32'd0);
        $display("mfhi rdata=%h", bus.md_rdata);
        check("mfhi_rsel", 64'(bus.md_rsel), 64'd1);
        check("mfhi_rdata", 64'(bus.md_rdata), 64'h1234);
        issue(2'b10, F_MFLO, 1'b1, 32'd0, 32'd0);
        $display("mflo rdata=%h", bus.md_rdata);
        check("mflo_rdata_mt", 64'(bus.md_rdata), 64'h5678);
        issue(2'b00, 6'd0, 1'b0, 32'd0, 32'd0);

        repeat (3) step();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
